noc_local_ni: RTL and testbench
===============================

Name: noc_local_ni

Overview:
Network interface that sits directly on a router's local port in the 2x2 mesh. Its flit-out port drives the router's Noc_x_y_receive_* inputs and its flit-in port consumes the router's Noc_x_y_sender_* outputs.
- TX path: packetizes a request (destination plus payload words) into header, body and tail flits.
- RX path: strips headers from arriving packets and delivers payload words with source coordinates.
It replaces hard-coded traffic generation with a reusable endpoint.

Parameters:
X_ID, 0, this node's X coordinate
Y_ID, 0, this node's Y coordinate
COORD_W, 4, width of each coordinate field
LEN_W, 8, payload-length field width; max payload 2^LEN_W-1 flits
W, `Noc_Data_Width, flit width; must satisfy W >= 4*COORD_W+LEN_W

Ports:
noc_clk  in  1  clock
noc_rst_n  in  1  async active-low reset
tx_req_valid  in  1  packet request valid
tx_req_ready  out  1  request accepted
tx_req_dest_x  in  COORD_W  destination X
tx_req_dest_y  in  COORD_W  destination Y
tx_req_len  in  LEN_W  payload flit count (0 legal)
tx_data_valid  in  1  payload word valid
tx_data_ready  out  1  payload word accepted
tx_data  in  W  payload word
sender_valid  out  1  flit to router valid
sender_ready  in  1  router accepts flit
sender_flit  out  W  flit
sender_is_header  out  1  header flit marker
sender_is_tail  out  1  tail flit marker
receive_valid  in  1  flit from router valid
receive_ready  out  1  NI accepts flit
receive_flit  in  W  flit
receive_is_header  in  1  header marker
receive_is_tail  in  1  tail marker
rx_valid  out  1  payload word valid
rx_ready  in  1  consumer accepts word
rx_data  out  W  payload word
rx_src_x  out  COORD_W  source X of current packet
rx_src_y  out  COORD_W  source Y of current packet
rx_last  out  1  final payload word of packet
rx_pkt_count  out  16  packets fully received, wraps at 65535->0
err_flags  out  3  sticky {len_mismatch, misroute, orphan_body}

Behaviour:
Reset and clocking:
- One clock, noc_clk. Reset is asynchronous and active-low on noc_rst_n.
- Reset clears all outputs, counters, flags and FSMs to 0/idle. A packet in progress is abandoned without a tail.

Header flit layout (LSB first):
- dest_y[COORD_W-1:0], then dest_x, then src_y, then src_x, then len[LEN_W-1:0].
- Remaining upper bits are 0.

TX FSM (T_IDLE, T_BODY):
- sender_* is a registered output stage. Once asserted, valid and all flit fields are held stable until sender_ready.
- tx_req_ready = (T_IDLE) && (!sender_valid || sender_ready).
- Request accept loads the header flit the next cycle with is_header=1.
  - len=0: is_tail=1 also; stay in T_IDLE.
  - len>0: load remaining=len and go to T_BODY.
- In T_BODY, tx_data_ready = !sender_valid || sender_ready. Full throughput is one flit per cycle.
- Each accepted word decrements remaining. The word with remaining==1 carries is_tail=1 and the FSM returns to T_IDLE.
- Latency: request accept to header valid is 1 cycle; data accept to flit valid is 1 cycle.

RX FSM (R_IDLE, R_BODY):
- receive_ready: 1 in R_IDLE; in R_BODY, !rx_valid || rx_ready.
- Header in R_IDLE:
  - latch src_x, src_y and len into expected count;
  - if is_tail (len=0 packet): increment rx_pkt_count, emit no rx word, stay in R_IDLE;
  - otherwise go to R_BODY.
- Body flit in R_BODY: loaded into the rx_* register stage and held until rx_ready.
  - rx_last = receive_is_tail.
  - Tail returns to R_IDLE and increments rx_pkt_count in the same accept cycle.
- Boundary conditions:
  - Non-header flit in R_IDLE: accepted and dropped; sets orphan_body.
  - Header arriving in R_BODY: treated as a new header and the old packet is abandoned; sets len_mismatch.
  - Tail arriving with count != expected, or count reaching expected without tail: sets len_mismatch. The packet ends on the tail.
  - Header whose dest differs from X_ID/Y_ID: sets misroute; the packet is still delivered.
- TX and RX are fully independent and may be simultaneously active.

Optional Feature:
NOC_NI_ERR_CHECK_EN
- Defined: err_flags are computed as above and cleared only by reset.
- Undefined: err_flags tied to 0 and the checking logic is omitted. Data paths and rx_pkt_count are unchanged; orphan flits are still dropped.

Test Plan:
- NI at (0,0): request dest=(1,1), len=3, words 0xA,0xB,0xC, sender_ready=1 -> 4 consecutive flits. Header has is_header=1, dest_x=1, dest_y=1, len=3. Last flit is 0xC with is_tail=1.
- Request len=0 -> single flit with is_header=1 and is_tail=1. Loopback RX: rx_pkt_count=1, no rx_valid.
- sender_ready held low 5 cycles mid-packet -> sender_flit stable, tx_data_ready=0. Resumes with no loss or duplication.
- RX header src=(1,0), len=2, body 0x11,0x22, rx_ready toggling -> rx_data 0x11 then 0x22 (rx_last=1), rx_src_x=1, rx_src_y=0, rx_pkt_count increments once.
- Body flit with no header, then header with dest=(1,1) at NI (0,0) -> orphan_body=1, misroute=1 (macro defined); err_flags=0 (undefined).
- noc_rst_n pulsed low mid-TX at remaining=2 -> sender_valid=0 immediately. After release, tx_req_ready=1 and a fresh packet sends correctly.

Source files
------------

// File: rtl/noc_local_ni.sv
// Mesh local-port network interface: packetizes TX requests into header/body/tail flits and strips headers on RX.
// Latency: request or data word accept to flit valid is 1 cycle; RX flit accept to rx word valid is 1 cycle.
// Backpressure: sender_*/rx_* are registered stages held until accepted; a stage reloads on the cycle its contents leave.
// Optional error checking is enabled with `define NOC_NI_ERR_CHECK_EN (err_flags tied to 0 otherwise).

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_local_ni #(
  parameter int X_ID    = 0,
  parameter int Y_ID    = 0,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 8,
  parameter int W       = `Noc_Data_Width
) (
  input  logic               noc_clk,
  input  logic               noc_rst_n,
  input  logic               tx_req_valid,
  output logic               tx_req_ready,
  input  logic [COORD_W-1:0] tx_req_dest_x,
  input  logic [COORD_W-1:0] tx_req_dest_y,
  input  logic [LEN_W-1:0]   tx_req_len,
  input  logic               tx_data_valid,
  output logic               tx_data_ready,
  input  logic [W-1:0]       tx_data,
  output logic               sender_valid,
  input  logic               sender_ready,
  output logic [W-1:0]       sender_flit,
  output logic               sender_is_header,
  output logic               sender_is_tail,
  input  logic               receive_valid,
  output logic               receive_ready,
  input  logic [W-1:0]       receive_flit,
  input  logic               receive_is_header,
  input  logic               receive_is_tail,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [W-1:0]       rx_data,
  output logic [COORD_W-1:0] rx_src_x,
  output logic [COORD_W-1:0] rx_src_y,
  output logic               rx_last,
  output logic [15:0]        rx_pkt_count,
  output logic [2:0]         err_flags
);

  // Header field boundaries, LSB first: dest_y, dest_x, src_y, src_x, len.
  localparam int HL = 4*COORD_W + LEN_W;

  typedef enum logic {T_IDLE, T_BODY} tx_state_e;
  typedef enum logic {R_IDLE, R_BODY} rx_state_e;

  // ---------------- TX path ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [LEN_W-1:0] tx_rem_q, tx_rem_d;
  logic             snd_vld_q, snd_vld_d;
  logic [W-1:0]     snd_flit_q, snd_flit_d;
  logic             snd_hdr_q, snd_hdr_d;
  logic             snd_tail_q, snd_tail_d;
  logic             tx_adv;

  // The output stage can take a new flit when it is empty or draining this cycle.
  assign tx_adv        = !snd_vld_q || sender_ready;
  assign tx_req_ready  = (tx_state_q == T_IDLE) && tx_adv;
  assign tx_data_ready = (tx_state_q == T_BODY) && tx_adv;

  assign sender_valid     = snd_vld_q;
  assign sender_flit      = snd_flit_q;
  assign sender_is_header = snd_hdr_q;
  assign sender_is_tail   = snd_tail_q;

  // TX next state: build the header on request accept, then stream body words until remaining hits 1.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_rem_d   = tx_rem_q;
    snd_vld_d  = snd_vld_q;
    snd_flit_d = snd_flit_q;
    snd_hdr_d  = snd_hdr_q;
    snd_tail_d = snd_tail_q;
    if (snd_vld_q && sender_ready) begin
      snd_vld_d = 1'b0;
    end
    if (tx_req_valid && tx_req_ready) begin
      snd_vld_d                            = 1'b1;
      snd_flit_d                           = '0;
      snd_flit_d[COORD_W-1:0]              = tx_req_dest_y;
      snd_flit_d[2*COORD_W-1:COORD_W]      = tx_req_dest_x;
      snd_flit_d[3*COORD_W-1:2*COORD_W]    = COORD_W'(Y_ID);
      snd_flit_d[4*COORD_W-1:3*COORD_W]    = COORD_W'(X_ID);
      snd_flit_d[HL-1:4*COORD_W]           = tx_req_len;
      snd_hdr_d                            = 1'b1;
      snd_tail_d                           = (tx_req_len == '0);
      if (tx_req_len != '0) begin
        tx_state_d = T_BODY;
        tx_rem_d   = tx_req_len;
      end
    end else if (tx_data_valid && tx_data_ready) begin
      snd_vld_d  = 1'b1;
      snd_flit_d = tx_data;
      snd_hdr_d  = 1'b0;
      snd_tail_d = (tx_rem_q == LEN_W'(1));
      tx_rem_d   = tx_rem_q - LEN_W'(1);
      if (tx_rem_q == LEN_W'(1)) begin
        tx_state_d = T_IDLE;
      end
    end
  end

  // TX state and output-stage registers.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      tx_state_q <= T_IDLE;
      tx_rem_q   <= '0;
      snd_vld_q  <= 1'b0;
      snd_flit_q <= '0;
      snd_hdr_q  <= 1'b0;
      snd_tail_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_rem_q   <= tx_rem_d;
      snd_vld_q  <= snd_vld_d;
      snd_flit_q <= snd_flit_d;
      snd_hdr_q  <= snd_hdr_d;
      snd_tail_q <= snd_tail_d;
    end
  end

  // ---------------- RX path ----------------
  rx_state_e          rx_state_q, rx_state_d;
  logic [COORD_W-1:0] pkt_sx_q, pkt_sx_d;
  logic [COORD_W-1:0] pkt_sy_q, pkt_sy_d;
  logic               rx_vld_q, rx_vld_d;
  logic [W-1:0]       rx_dat_q, rx_dat_d;
  logic [COORD_W-1:0] rx_sx_q, rx_sx_d;
  logic [COORD_W-1:0] rx_sy_q, rx_sy_d;
  logic               rx_last_q, rx_last_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic               rx_acc;

`ifdef NOC_NI_ERR_CHECK_EN
  logic [LEN_W-1:0] exp_q, exp_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       err_q, err_d;
  logic [LEN_W-1:0] hdr_len;
  assign hdr_len   = receive_flit[HL-1:4*COORD_W];
  assign err_flags = err_q;
`else
  assign err_flags = 3'b000;
`endif

  // Headers are always taken in R_IDLE; body flits need the rx word stage free.
  assign receive_ready = (rx_state_q == R_IDLE) || !rx_vld_q || rx_ready;
  assign rx_acc        = receive_valid && receive_ready;

  assign rx_valid     = rx_vld_q;
  assign rx_data      = rx_dat_q;
  assign rx_src_x     = rx_sx_q;
  assign rx_src_y     = rx_sy_q;
  assign rx_last      = rx_last_q;
  assign rx_pkt_count = pkt_cnt_q;

  // RX next state: latch source on header, forward body words, count packets on tail.
  // The source is copied into the word stage with each word so a following header cannot disturb a held word.
  always_comb begin
    rx_state_d = rx_state_q;
    pkt_sx_d   = pkt_sx_q;
    pkt_sy_d   = pkt_sy_q;
    rx_vld_d   = rx_vld_q;
    rx_dat_d   = rx_dat_q;
    rx_sx_d    = rx_sx_q;
    rx_sy_d    = rx_sy_q;
    rx_last_d  = rx_last_q;
    pkt_cnt_d  = pkt_cnt_q;
`ifdef NOC_NI_ERR_CHECK_EN
    exp_d = exp_q;
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    if (rx_vld_q && rx_ready) begin
      rx_vld_d = 1'b0;
    end
    if (rx_acc) begin
      if (receive_is_header) begin
        pkt_sx_d = receive_flit[4*COORD_W-1:3*COORD_W];
        pkt_sy_d = receive_flit[3*COORD_W-1:2*COORD_W];
`ifdef NOC_NI_ERR_CHECK_EN
        exp_d = hdr_len;
        cnt_d = '0;
        if (receive_flit[2*COORD_W-1:COORD_W] != COORD_W'(X_ID) ||
            receive_flit[COORD_W-1:0] != COORD_W'(Y_ID)) begin
          err_d[1] = 1'b1;
        end
        // A header cutting into a packet, or a header-only packet claiming a payload, is a length error.
        if (rx_state_q == R_BODY || (receive_is_tail && hdr_len != '0)) begin
          err_d[2] = 1'b1;
        end
`endif
        if (receive_is_tail) begin
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
          rx_state_d = R_IDLE;
        end else begin
          rx_state_d = R_BODY;
        end
      end else if (rx_state_q == R_BODY) begin
        rx_vld_d  = 1'b1;
        rx_dat_d  = receive_flit;
        rx_sx_d   = pkt_sx_q;
        rx_sy_d   = pkt_sy_q;
        rx_last_d = receive_is_tail;
`ifdef NOC_NI_ERR_CHECK_EN
        cnt_d = cnt_q + LEN_W'(1);
        if (receive_is_tail ? (cnt_d != exp_q) : (cnt_d == exp_q)) begin
          err_d[2] = 1'b1;
        end
`endif
        if (receive_is_tail) begin
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
          rx_state_d = R_IDLE;
        end
      end else begin
        // Body flit with no packet open: swallowed.
`ifdef NOC_NI_ERR_CHECK_EN
        err_d[0] = 1'b1;
`endif
      end
    end
  end

  // RX state, word stage and packet counter registers.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      rx_state_q <= R_IDLE;
      pkt_sx_q   <= '0;
      pkt_sy_q   <= '0;
      rx_vld_q   <= 1'b0;
      rx_dat_q   <= '0;
      rx_sx_q    <= '0;
      rx_sy_q    <= '0;
      rx_last_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      pkt_sx_q   <= pkt_sx_d;
      pkt_sy_q   <= pkt_sy_d;
      rx_vld_q   <= rx_vld_d;
      rx_dat_q   <= rx_dat_d;
      rx_sx_q    <= rx_sx_d;
      rx_sy_q    <= rx_sy_d;
      rx_last_q  <= rx_last_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

`ifdef NOC_NI_ERR_CHECK_EN
  // Length tracking and sticky error flags, cleared only by reset.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      exp_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      exp_q <= exp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// Scoreboard bench for noc_local_ni at node (0,0): drivers push expected flits/words, negedge monitors pop and compare.
// Directed cases cover the basic packet, len=0, stalls, RX errors and mid-packet reset; then a random concurrent phase.
// Header layout assumed: [3:0] dest_y, [7:4] dest_x, [11:8] src_y, [15:12] src_x, [23:16] len.

module tb_noc_local_ni;

  logic        noc_clk, noc_rst_n;
  logic        tx_req_valid, tx_req_ready;
  logic [3:0]  tx_req_dest_x, tx_req_dest_y;
  logic [7:0]  tx_req_len;
  logic        tx_data_valid, tx_data_ready;
  logic [31:0] tx_data;
  logic        sender_valid, sender_ready;
  logic [31:0] sender_flit;
  logic        sender_is_header, sender_is_tail;
  logic        receive_valid, receive_ready;
  logic [31:0] receive_flit;
  logic        receive_is_header, receive_is_tail;
  logic        rx_valid, rx_ready;
  logic [31:0] rx_data;
  logic [3:0]  rx_src_x, rx_src_y;
  logic        rx_last;
  logic [15:0] rx_pkt_count;
  logic [2:0]  err_flags;

  noc_local_ni #(.X_ID(0), .Y_ID(0), .COORD_W(4), .LEN_W(8), .W(32)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .tx_req_valid(tx_req_valid), .tx_req_ready(tx_req_ready),
    .tx_req_dest_x(tx_req_dest_x), .tx_req_dest_y(tx_req_dest_y), .tx_req_len(tx_req_len),
    .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready), .tx_data(tx_data),
    .sender_valid(sender_valid), .sender_ready(sender_ready), .sender_flit(sender_flit),
    .sender_is_header(sender_is_header), .sender_is_tail(sender_is_tail),
    .receive_valid(receive_valid), .receive_ready(receive_ready), .receive_flit(receive_flit),
    .receive_is_header(receive_is_header), .receive_is_tail(receive_is_tail),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_src_x(rx_src_x), .rx_src_y(rx_src_y), .rx_last(rx_last),
    .rx_pkt_count(rx_pkt_count), .err_flags(err_flags)
  );

  typedef struct packed {logic [31:0] f; logic h; logic t;} txe_t;
  typedef struct packed {logic [31:0] d; logic [3:0] sx; logic [3:0] sy; logic l;} rxe_t;

  int          checks;
  int          errors;
  txe_t        tx_q[$];
  rxe_t        rx_q[$];
  logic [15:0] pkt_exp;
  logic [2:0]  err_exp;
  bit          in_pkt;
  logic [3:0]  cur_sx, cur_sy;
  int          exp_len, got;
  bit          hold_p;
  txe_t        held;
  bit          sr_rand, rr_rand;

  initial begin
    noc_clk = 1'b0;
    forever #5 noc_clk = ~noc_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", nm);
  endtask

  function automatic logic [2:0] err_req();
`ifdef NOC_NI_ERR_CHECK_EN
    return err_exp;
`else
    return 3'b000;
`endif
  endfunction

  function automatic bit rdy(input int k);
    case (k)
      0:       return tx_req_ready;
      1:       return tx_data_ready;
      default: return receive_ready;
    endcase
  endfunction

  // Waits until ready is seen at a negedge, then returns just after the accepting posedge.
  task automatic handshake(input int k, input string nm);
    int t;
    t = 0;
    forever begin
      @(negedge noc_clk);
      if (rdy(k)) break;
      t++;
      if (t > 500) begin
        fail_to(nm);
        break;
      end
    end
    @(posedge noc_clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge noc_clk);
      #1;
    end
  endtask

  task automatic send_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len,
                          input bit rnd, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input bit gaps);
    logic [31:0] d;
    tx_req_dest_x = dx;
    tx_req_dest_y = dy;
    tx_req_len    = len;
    tx_req_valid  = 1'b1;
    handshake(0, "tx_req_accept");
    tx_q.push_back('{f: {8'h00, len, 4'h0, 4'h0, dx, dy}, h: 1'b1, t: (len == 0)});
    #1 tx_req_valid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      if (gaps) idle_cycles($urandom_range(0, 2));
      d = rnd ? $urandom : (i == 0 ? w0 : (i == 1 ? w1 : w2));
      tx_data       = d;
      tx_data_valid = 1'b1;
      handshake(1, "tx_data_accept");
      tx_q.push_back('{f: d, h: 1'b0, t: (i == int'(len) - 1)});
      #1 tx_data_valid = 1'b0;
    end
  endtask

  // Reference RX behaviour: words after a header carry that header's source; tails close packets.
  task automatic rx_send(input logic [31:0] f, input bit h, input bit t);
    receive_flit      = f;
    receive_is_header = h;
    receive_is_tail   = t;
    receive_valid     = 1'b1;
    handshake(2, "rx_accept");
    if (h) begin
      if (in_pkt) err_exp[2] = 1'b1;
      cur_sx  = f[15:12];
      cur_sy  = f[11:8];
      exp_len = int'(f[23:16]);
      got     = 0;
      if (f[7:0] != 8'h00) err_exp[1] = 1'b1;
      if (t) begin
        if (exp_len != 0) err_exp[2] = 1'b1;
        pkt_exp = pkt_exp + 16'd1;
        in_pkt  = 1'b0;
      end else begin
        in_pkt = 1'b1;
      end
    end else if (in_pkt) begin
      got++;
      rx_q.push_back('{d: f, sx: cur_sx, sy: cur_sy, l: t});
      if (t) begin
        if (got != exp_len) err_exp[2] = 1'b1;
        pkt_exp = pkt_exp + 16'd1;
        in_pkt  = 1'b0;
      end else if (got == exp_len) begin
        err_exp[2] = 1'b1;
      end
    end else begin
      err_exp[0] = 1'b1;
    end
    #1 receive_valid = 1'b0;
  endtask

  task automatic rx_packet(input logic [3:0] sx, input logic [3:0] sy, input logic [3:0] dx,
                           input logic [3:0] dy, input logic [7:0] len, input bit rnd,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] d;
    rx_send({8'h00, len, sx, sy, dx, dy}, 1'b1, (len == 0));
    for (int i = 0; i < int'(len); i++) begin
      if (rnd) idle_cycles($urandom_range(0, 1));
      d = rnd ? $urandom : (i == 0 ? w0 : (i == 1 ? w1 : w2));
      rx_send(d, 1'b0, (i == int'(len) - 1));
    end
  endtask

  task automatic apply_reset();
    noc_rst_n     = 1'b0;
    tx_req_valid  = 1'b0;
    tx_data_valid = 1'b0;
    receive_valid = 1'b0;
    tx_q.delete();
    rx_q.delete();
    pkt_exp = '0;
    err_exp = '0;
    in_pkt  = 1'b0;
    hold_p  = 1'b0;
    repeat (2) @(negedge noc_clk);
    #1 noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0) && t < 1000) begin
      @(posedge noc_clk);
      t++;
    end
    if (t >= 1000) fail_to("drain");
    idle_cycles(2);
  endtask

  // Random backpressure on both output ports when enabled.
  initial begin
    forever begin
      @(posedge noc_clk);
      #1;
      if (sr_rand) sender_ready = ($urandom_range(0, 3) != 0);
      if (rr_rand) rx_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // TX monitor: held flits must stay stable; accepted flits must match the scoreboard.
  initial begin
    forever begin
      @(negedge noc_clk);
      if (noc_rst_n) begin : tx_mon
        txe_t cur;
        txe_t e;
        cur = {sender_flit, sender_is_header, sender_is_tail};
        if (hold_p) begin
          chk("tx_hold_valid", 64'(sender_valid), 64'd1);
          if (sender_valid) chk("tx_hold_flit", 64'(cur), 64'(held));
        end
        hold_p = 1'b0;
        if (sender_valid) begin
          if (sender_ready) begin
            if (tx_q.size() == 0) begin
              fail_to("tx_unexpected_flit");
            end else begin
              e = tx_q.pop_front();
              chk("tx_flit", 64'(cur), 64'(e));
            end
          end else begin
            hold_p = 1'b1;
            held   = cur;
          end
        end
      end
    end
  end

  // RX monitor: delivered words, packet count and error flags.
  initial begin
    forever begin
      @(negedge noc_clk);
      if (noc_rst_n) begin : rx_mon
        rxe_t cur;
        rxe_t e;
        cur = {rx_data, rx_src_x, rx_src_y, rx_last};
        if (rx_valid && rx_ready) begin
          if (rx_q.size() == 0) begin
            fail_to("rx_unexpected_word");
          end else begin
            e = rx_q.pop_front();
            chk("rx_word", 64'(cur), 64'(e));
          end
        end
        chk("rx_pkt_count", 64'(rx_pkt_count), 64'(pkt_exp));
        chk("err_flags", 64'(err_flags), 64'(err_req()));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    sr_rand = 1'b0;
    rr_rand = 1'b0;
    hold_p  = 1'b0;
    noc_rst_n = 1'b0;
    tx_req_valid = 1'b0; tx_req_dest_x = '0; tx_req_dest_y = '0; tx_req_len = '0;
    tx_data_valid = 1'b0; tx_data = '0;
    sender_ready = 1'b0;
    receive_valid = 1'b0; receive_flit = '0; receive_is_header = 1'b0; receive_is_tail = 1'b0;
    rx_ready = 1'b0;
    cur_sx = '0; cur_sy = '0; exp_len = 0; got = 0;
    apply_reset();

    chk("rst_sender_valid", 64'(sender_valid), 64'd0);
    chk("rst_tx_req_ready", 64'(tx_req_ready), 64'd1);
    chk("rst_tx_data_ready", 64'(tx_data_ready), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_receive_ready", 64'(receive_ready), 64'd1);
    chk("rst_pkt_count", 64'(rx_pkt_count), 64'd0);
    chk("rst_err_flags", 64'(err_flags), 64'd0);

    sender_ready = 1'b1;
    rx_ready     = 1'b1;

    // Basic packet to (1,1) with three words.
    send_pkt(4'd1, 4'd1, 8'd3, 1'b0, 32'hA, 32'hB, 32'hC, 1'b0);
    drain();

    // Zero-length packet to self, looped back into RX.
    send_pkt(4'd0, 4'd0, 8'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    drain();
    rx_send(32'h0000_0000, 1'b1, 1'b1);
    idle_cycles(2);
    chk("len0_no_rx_valid", 64'(rx_valid), 64'd0);
    chk("len0_pkt_count", 64'(rx_pkt_count), 64'd1);

    // Five-cycle stall on the router side mid-packet.
    fork
      send_pkt(4'd1, 4'd0, 8'd4, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
      begin
        int t;
        t = 0;
        forever begin
          @(negedge noc_clk);
          t++;
          if (sender_valid && !sender_is_header) break;
          if (t > 200) begin
            fail_to("stall_body_wait");
            break;
          end
        end
        @(posedge noc_clk);
        #1 sender_ready = 1'b0;
        repeat (5) begin
          @(negedge noc_clk);
          chk("stall_sender_valid", 64'(sender_valid), 64'd1);
          chk("stall_tx_data_ready", 64'(tx_data_ready), 64'd0);
        end
        @(posedge noc_clk);
        #1 sender_ready = 1'b1;
      end
    join
    drain();

    // RX packet from (1,0) with a toggling consumer.
    rr_rand = 1'b1;
    rx_packet(4'd1, 4'd0, 4'd0, 4'd0, 8'd2, 1'b0, 32'h11, 32'h22, 32'h0);
    drain();
    rr_rand = 1'b0;
    rx_ready = 1'b1;
    chk("rx_pkt_count_after_rx", 64'(rx_pkt_count), 64'd2);

    // Orphan body flit, then a misrouted packet that is still delivered.
    rx_send(32'h55, 1'b0, 1'b0);
    rx_packet(4'd1, 4'd1, 4'd1, 4'd1, 8'd1, 1'b0, 32'h77, 32'h0, 32'h0);
    drain();
`ifdef NOC_NI_ERR_CHECK_EN
    chk("err_orphan_misroute", 64'(err_flags), 64'h3);
`else
    chk("err_orphan_misroute", 64'(err_flags), 64'h0);
`endif

    // Short packet (tail early) and a header cutting into an open packet.
    rx_send({8'h00, 8'd3, 4'd0, 4'd1, 4'd0, 4'd0}, 1'b1, 1'b0);
    rx_send(32'h31, 1'b0, 1'b0);
    rx_send(32'h32, 1'b0, 1'b1);
    rx_send({8'h00, 8'd2, 4'd1, 4'd1, 4'd0, 4'd0}, 1'b1, 1'b0);
    rx_send(32'h41, 1'b0, 1'b0);
    rx_packet(4'd0, 4'd1, 4'd0, 4'd0, 8'd1, 1'b0, 32'h51, 32'h0, 32'h0);
    drain();
`ifdef NOC_NI_ERR_CHECK_EN
    chk("err_len_mismatch", 64'(err_flags), 64'h7);
`else
    chk("err_len_mismatch", 64'(err_flags), 64'h0);
`endif

    // Reset with two body words still to go.
    tx_req_dest_x = 4'd1;
    tx_req_dest_y = 4'd1;
    tx_req_len    = 8'd4;
    tx_req_valid  = 1'b1;
    handshake(0, "mid_req_accept");
    tx_q.push_back('{f: {8'h00, 8'd4, 4'h0, 4'h0, 4'd1, 4'd1}, h: 1'b1, t: 1'b0});
    #1 tx_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tx_data       = 32'h100 + i;
      tx_data_valid = 1'b1;
      handshake(1, "mid_data_accept");
      tx_q.push_back('{f: 32'h100 + i, h: 1'b0, t: 1'b0});
      #1 tx_data_valid = 1'b0;
    end
    noc_rst_n = 1'b0;
    #1;
    chk("async_rst_sender_valid", 64'(sender_valid), 64'd0);
    apply_reset();
    chk("post_rst_tx_req_ready", 64'(tx_req_ready), 64'd1);
    chk("post_rst_pkt_count", 64'(rx_pkt_count), 64'd0);
    send_pkt(4'd0, 4'd1, 8'd2, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    drain();

    // Random concurrent TX and RX traffic with random backpressure.
    sr_rand = 1'b1;
    rr_rand = 1'b1;
    fork
      for (int p = 0; p < 25; p++)
        send_pkt(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 6)),
                 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
      for (int p = 0; p < 25; p++) begin
        if ($urandom_range(0, 9) == 0) rx_send($urandom, 1'b0, 1'b0);
        rx_packet(4'($urandom_range(0, 1)), 4'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 1)) : 4'd0, 4'd0,
                  8'($urandom_range(0, 5)), 1'b1, 32'h0, 32'h0, 32'h0);
      end
    join
    sr_rand = 1'b0;
    rr_rand = 1'b0;
    sender_ready = 1'b1;
    rx_ready     = 1'b1;
    drain();
    chk("final_tx_queue_empty", 64'(tx_q.size()), 64'd0);
    chk("final_rx_queue_empty", 64'(rx_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
